// File: rtl/seg7_pkg.sv
// Shared state encoding and active-high segment patterns for the 7-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_UNITS = 2'd0,
        S_GAP0  = 2'd1,
        S_TENS  = 2'd2,
        S_GAP1  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment lookup (active-high); non-BCD codes show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed 7-segment driver with guard gaps and leading-zero blanking.
// Define DISP_BLINK_EN to build the blink input, frame counter and blink phase.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter int GAP_CYCLES     = 2,
    parameter int BLINK_DIV      = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       blank_lz,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [1:0] dig_an
);

    localparam int MAX_DUR = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int TMR_W   = $clog2(MAX_DUR);
    localparam logic [TMR_W-1:0] SHOW_LD = TMR_W'(REFRESH_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [6:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [1:0] AN_RST  = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    state_t           state, state_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic [3:0]       tens_q, units_q;
    logic [3:0]       digit_sel;
    logic [6:0]       seg_dec;
    logic [6:0]       seg_p0;
    logic [1:0]       an_p0;
    logic             expire;
    logic             dark;

    assign expire = (timer == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else if (load) begin
            tens_q  <= tens;
            units_q <= units;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_UNITS;
            timer <= SHOW_LD;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    // One down-counter times every slot; it reloads with the next slot's length on expiry.
    always_comb begin
        state_nx = state;
        timer_nx = timer - TMR_W'(1);
        if (expire) begin
            unique case (state)
                S_UNITS: begin state_nx = S_GAP0;  timer_nx = GAP_LD;  end
                S_GAP0:  begin state_nx = S_TENS;  timer_nx = SHOW_LD; end
                S_TENS:  begin state_nx = S_GAP1;  timer_nx = GAP_LD;  end
                S_GAP1:  begin state_nx = S_UNITS; timer_nx = SHOW_LD; end
            endcase
        end
    end

`ifdef DISP_BLINK_EN
    localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [FRM_W-1:0] frame_cnt;
    logic             blink_ph;

    // Phase flips every BLINK_DIV frames; with blink low the display is forced on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (!blink) begin
            frame_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (expire && state == S_GAP1) begin
            if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
                frame_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                frame_cnt <= frame_cnt + FRM_W'(1);
            end
        end
    end

    assign dark = blink && !blink_ph;
`else
    logic unused_blink;
    assign unused_blink = blink;
    assign dark = 1'b0;
`endif

    assign digit_sel = (state == S_TENS) ? tens_q : units_q;

    seg7_decode u_decode (
        .digit (digit_sel),
        .seg   (seg_dec)
    );

    always_comb begin
        seg_p0 = SEG_OFF;
        an_p0  = 2'b00;
        case (state)
            S_UNITS: begin
                seg_p0 = seg_dec;
                an_p0  = 2'b01;
            end
            S_TENS: begin
                if (!(blank_lz && tens_q == 4'd0)) begin
                    seg_p0 = seg_dec;
                    an_p0  = 2'b10;
                end
            end
            default: ;
        endcase
        if (dark) an_p0 = 2'b00;
    end

    // Output registers: the only place polarity is applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg    <= SEG_RST;
            dig_an <= AN_RST;
        end else begin
            seg    <= (SEG_ACTIVE_LOW != 0) ? ~seg_p0 : seg_p0;
            dig_an <= (AN_ACTIVE_LOW != 0) ? ~an_p0 : an_p0;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed table-driven bench for seg7_mux_driver (REFRESH_DIV=4, GAP_CYCLES=1, active-low).
module tb_seg7_mux_driver;

    localparam int RD = 4;
    localparam int GC = 1;
    localparam int BD = 2;
`ifdef DISP_BLINK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    typedef struct {
        logic [3:0] tens;
        logic [3:0] units;
        logic       blank;
        logic [6:0] seg_u;
        logic [6:0] seg_t;
        logic [1:0] an_t;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] tens;
    logic [3:0] units;
    logic       blank_lz;
    logic       blink;
    logic [6:0] seg;
    logic [1:0] dig_an;

    int errors = 0;
    int checks = 0;
    int k = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    seg7_mux_driver #(
        .REFRESH_DIV    (RD),
        .GAP_CYCLES     (GC),
        .BLINK_DIV      (BD),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .tens     (tens),
        .units    (units),
        .blank_lz (blank_lz),
        .blink    (blink),
        .seg      (seg),
        .dig_an   (dig_an)
    );

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic check(input string name, input logic [6:0] s_exp, input logic [1:0] a_exp);
        checks++;
        if (seg !== s_exp || dig_an !== a_exp) begin
            errors++;
            $display("FAIL %s k=%0d: got seg=%h dig_an=%b, expected seg=%h dig_an=%b",
                     name, k, seg, dig_an, s_exp, a_exp);
        end
    endtask

    task automatic check_an(input string name, input logic [1:0] a_exp);
        checks++;
        if (dig_an !== a_exp) begin
            errors++;
            $display("FAIL %s k=%0d: got dig_an=%b, expected dig_an=%b", name, k, dig_an, a_exp);
        end
    endtask

    // Reset (checked asynchronously), then release so that the next edge is k=1 with load held.
    task automatic do_reset(input logic ld, input logic [3:0] t, input logic [3:0] u,
                            input logic bl, input logic bk);
        rst = 1'b1;
        #1;
        check("reset_outputs", 7'h7F, 2'b11);
        load = ld; tens = t; units = u; blank_lz = bl; blink = bk;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        step();
        load = 1'b0;
        check("first_units_zero", 7'h40, 2'b10);
    endtask

    // Output phase within the 10-cycle frame: 4 units, 1 gap, 4 tens, 1 gap.
    function automatic void exp_at(input vec_t v, input int kk,
                                   output logic [6:0] s, output logic [1:0] a);
        int p;
        p = (kk - 1) % 10;
        if (p < 4) begin
            s = v.seg_u; a = 2'b10;
        end else if (p == 4 || p == 9) begin
            s = 7'h7F; a = 2'b11;
        end else begin
            s = v.seg_t; a = v.an_t;
        end
    endfunction

    initial begin
        logic [6:0] s_e;
        logic [1:0] a_e;
        vecs[0] = '{4'd4,  4'd2,  1'b0, 7'h24, 7'h19, 2'b01};
        vecs[1] = '{4'd0,  4'd0,  1'b1, 7'h40, 7'h7F, 2'b11};
        vecs[2] = '{4'd12, 4'd15, 1'b0, 7'h3F, 7'h3F, 2'b01};
        vecs[3] = '{4'd0,  4'd7,  1'b0, 7'h78, 7'h40, 2'b01};
        vecs[4] = '{4'd9,  4'd8,  1'b1, 7'h00, 7'h10, 2'b01};
        vecs[5] = '{4'd0,  4'd5,  1'b1, 7'h12, 7'h7F, 2'b11};

        rst = 1'b0; load = 1'b0; tens = 4'd0; units = 4'd0; blank_lz = 1'b0; blink = 1'b0;
        #3;

        // Table: one full frame checked cycle by cycle after the load settles.
        for (int i = 0; i < 6; i++) begin
            do_reset(1'b1, vecs[i].tens, vecs[i].units, vecs[i].blank, 1'b0);
            for (int kk = 11; kk <= 20; kk++) begin
                run_to(kk);
                exp_at(vecs[i], kk, s_e, a_e);
                check($sformatf("vec%0d_frame", i), s_e, a_e);
            end
        end

        // Load during S_GAP0: units slot before it keeps the old value.
        do_reset(1'b1, 4'd4, 4'd2, 1'b0, 1'b0);
        run_to(14);
        check("gapload_prev_units", 7'h24, 2'b10);
        tens = 4'd7; units = 4'd3; load = 1'b1;
        step();
        load = 1'b0;
        check("gapload_gap", 7'h7F, 2'b11);
        run_to(16);
        check("gapload_tens_first", 7'h78, 2'b01);
        run_to(19);
        check("gapload_tens_last", 7'h78, 2'b01);
        run_to(21);
        check("gapload_next_units", 7'h30, 2'b10);

        // Reset mid-S_TENS: outputs drop immediately, shadows clear.
        run_to(27);
        check("pre_reset_tens", 7'h78, 2'b01);
        do_reset(1'b0, 4'd9, 4'd9, 1'b0, 1'b0);
        run_to(6);
        check("post_reset_tens_zero", 7'h40, 2'b01);

        // Blink with BLINK_DIV=2: on for frames 1-2, dark for 3-4, on for 5-6.
        do_reset(1'b1, 4'd4, 4'd2, 1'b0, 1'b1);
        run_to(11); check_an("blink_on_f2_units", 2'b10);
        run_to(16); check_an("blink_on_f2_tens", 2'b01);
        run_to(21); check_an("blink_dark_f3_units", BLK ? 2'b11 : 2'b10);
        run_to(26); check_an("blink_dark_f3_tens", BLK ? 2'b11 : 2'b01);
        run_to(31); check_an("blink_dark_f4_units", BLK ? 2'b11 : 2'b10);
        run_to(36); check_an("blink_dark_f4_tens", BLK ? 2'b11 : 2'b01);
        run_to(41); check_an("blink_on_f5_units", 2'b10);
        run_to(46); check_an("blink_on_f5_tens", 2'b01);
        run_to(61); check_an("blink_dark_f7_units", BLK ? 2'b11 : 2'b10);
        run_to(62);
        blink = 1'b0;
        step();
        check("blink_release", 7'h24, 2'b10);
        run_to(66);
        check("blink_release_tens", 7'h19, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
